uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART link. It synchronizes the serial rx line, detects the start bit, and times each bit period from the board clock. It sequences an internal shift register to take one sample at each bit midpoint, checks the stop bit, and hands the assembled word to downstream logic over a valid/ready handshake. It reports framing and overrun errors and is the counterpart of the UART transmitter, using the same bit-period divider.

Parameters:
packetSize, 8, data bits per frame (LSB transmitted first); legal range 2..16
cycleDiv, 100, clk cycles per bit period; must match the transmitter; minimum 4 (elaboration-time assertion)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
dReady  input  1  downstream accepts dOut this cycle
clrErr  input  1  clears the sticky overrun flag
dOut  output  packetSize  last completed word; reset 0
dValid  output  1  dOut holds an unconsumed word; reset 0
frameErr  output  1  one-cycle pulse on a bad stop bit; reset 0
overrun  output  1  sticky flag, set when an unconsumed word is overwritten; reset 0
busy  output  1  high in every state except IDLE; reset 0
sampleStrobe  output  1  one-cycle pulse at each midpoint sample (debug); reset 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high. Reset mid-frame returns to IDLE: all outputs 0, counters 0, shift register 0, synchronizer flops set to 1.
- rx synchronizer: two flops. rxS is the second flop. All decisions use rxS, so detection latency is 2 cycles.
- Bit counter cnt, width clog2(cycleDiv):
  - Cleared on entry to START.
  - Increments every non-IDLE cycle and wraps from cycleDiv-1 to 0.
  - A midpoint event, mid, occurs when cnt == cycleDiv/2 (integer division). sampleStrobe = mid.
- States:
  - IDLE: when rxS == 0, go to START with cnt = 0.
  - START: at mid, if rxS == 1 this is a false start; go to IDLE with no outputs. Otherwise continue; at wrap go to DATA with bitIdx = 0.
  - DATA: at mid, shift the register right and load rxS into the MSB; bitIdx++. At wrap with bitIdx == packetSize, go to STOP.
  - STOP: at mid:
    - If rxS == 1, load dOut from the shift register, set dValid, and go to IDLE immediately. Going half a bit early lets a back-to-back start be caught.
    - If rxS == 0, pulse frameErr for 1 cycle, discard the word, and go to BRK.
  - BRK: wait for rxS == 1, then go to IDLE. No start detection occurs in BRK.
- Handshake:
  - dValid and dOut hold stable until a cycle where dValid && dReady, after which dValid = 0 next cycle.
  - New word loaded while dValid == 1 and dReady == 0: overwrite dOut, dValid stays 1, overrun set.
  - New word loaded in the same cycle as consumption (dValid && dReady): dOut takes the new word, dValid stays 1, no overrun.
  - dReady while dValid == 0 is ignored.
- overrun clears on clrErr or reset. If clrErr arrives in the same cycle as a new overrun event, set wins.
- Latency: dValid rises on the clock edge after the stop-bit mid sample, about 9.5 bit periods plus 2 cycles after the rx falling edge (packetSize = 8).

Decomposition:
- Package uart_pkg:
  - rx state enum {IDLE, START, DATA, STOP, BRK}.
  - Shift-code constants SHIFT_NONE = 2'd0, SHIFT_RIGHT = 2'd1, SHIFT_LEFT = 2'd2.
  - Function computing the counter width from cycleDiv.
- One sub-module, uart_rx_shiftreg:
  - Parameter packetSize; ports clk, reset, LD, msbLD, shift[1:0], din, q.
  - Plain register with synchronous reset and no internal timing; the controller supplies every strobe.

Test Plan:
(all at cycleDiv = 16, packetSize = 8)
- Frame 0xA5 with valid stop, dReady = 1 -> exactly one dValid cycle, dOut = 0xA5, 10 sampleStrobes each at cnt = 8, frameErr = 0.
- rx low for 5 cycles then high -> false start detected at START mid; dValid stays 0, busy returns 0, no sampleStrobe after the first.
- Frame 0x3C with stop bit 0, line low 40 more cycles -> frameErr pulses 1 cycle, no dValid, busy held until rx high, then next frame 0x81 is received correctly.
- Frames 0x3C then 0xC3 with dReady = 0 -> dOut = 0xC3, dValid = 1, overrun = 1. clrErr pulse -> overrun = 0, dOut unchanged.
- Back-to-back frames with dReady asserted exactly on the second load cycle -> dOut = second word, dValid = 1, overrun = 0.
- reset asserted for 1 cycle during DATA bit 3 of frame 0xFF -> next cycle all outputs 0 and busy = 0; subsequent frame 0x5A yields dOut = 0x5A with no error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_e;

    localparam logic [1:0] SHIFT_NONE  = 2'd0;
    localparam logic [1:0] SHIFT_RIGHT = 2'd1;
    localparam logic [1:0] SHIFT_LEFT  = 2'd2;

    // Width of a counter that spans 0 .. div-1.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_shiftreg.sv
// Strobe-driven shift register: parallel load wins over shifting; msbLD is the serial bit fed in.
module uart_rx_shiftreg
    import uart_pkg::*;
#(
    parameter int packetSize = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  LD,
    input  logic                  msbLD,
    input  logic [1:0]            shift,
    input  logic [packetSize-1:0] din,
    output logic [packetSize-1:0] q
);

    logic [packetSize-1:0] q_q;
    logic [packetSize-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (LD) begin
            q_d = din;
        end else begin
            case (shift)
                SHIFT_RIGHT: q_d = {msbLD, q_q[packetSize-1:1]};
                SHIFT_LEFT:  q_d = {q_q[packetSize-2:0], msbLD};
                default:     q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop rx synchronizer, mid-bit sampling FSM, valid/ready output with
// framing-error pulse and sticky overrun flag.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int packetSize = 8,
    parameter int cycleDiv   = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  dReady,
    input  logic                  clrErr,
    output logic [packetSize-1:0] dOut,
    output logic                  dValid,
    output logic                  frameErr,
    output logic                  overrun,
    output logic                  busy,
    output logic                  sampleStrobe
);

    localparam int CW = cnt_width(cycleDiv);
    localparam int BW = $clog2(packetSize + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(cycleDiv / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(cycleDiv - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(packetSize);

    if (cycleDiv < 4) begin : g_div_chk
        $error("uart_rx_ctrl: cycleDiv must be at least 4");
    end
    if (packetSize < 2 || packetSize > 16) begin : g_size_chk
        $error("uart_rx_ctrl: packetSize must be in 2..16");
    end

    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_sync_q, rx_sync_d;
    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [packetSize-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    logic                  mid;
    logic                  wrap;
    logic                  word_load;
    logic                  sr_ld;
    logic [1:0]            sr_shift;
    logic [packetSize-1:0] sr_q;

    assign mid  = (cnt_q == CNT_MID);
    assign wrap = (cnt_q == CNT_LAST);

    uart_rx_shiftreg #(
        .packetSize(packetSize)
    ) u_shiftreg (
        .clk   (clk),
        .reset (reset),
        .LD    (sr_ld),
        .msbLD (rx_sync_q),
        .shift (sr_shift),
        .din   ({packetSize{1'b0}}),
        .q     (sr_q)
    );

    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        sr_ld       = 1'b0;
        sr_shift    = SHIFT_NONE;
        word_load   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                // Clearing the shift register here means a discarded word never leaks out.
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    sr_ld   = 1'b1;
                end
            end
            START: begin
                if (mid && rx_sync_q) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (mid) begin
                    sr_shift  = SHIFT_RIGHT;
                    bit_idx_d = bit_idx_q + BW'(1);
                end
                if (wrap && bit_idx_q == BIT_LAST) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start.
                if (mid) begin
                    if (rx_sync_q) begin
                        word_load = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end
            end
            BRK: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dout_d   = word_load ? sr_q : dout_q;
        dvalid_d = word_load | (dvalid_q & ~dReady);
        // Setting beats clearing when both land in the same cycle.
        if (word_load && dvalid_q && !dReady) begin
            overrun_d = 1'b1;
        end else if (clrErr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dOut         = dout_q;
    assign dValid       = dvalid_q;
    assign frameErr     = frame_err_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);
    assign sampleStrobe = mid && (state_q == START || state_q == DATA || state_q == STOP);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random frames, checked every cycle against
// a frame-timing model driven by elapsed cycles since start detection.
module tb_uart_rx_ctrl;

    localparam int P = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic         dReady = 1'b0;
    logic         clrErr = 1'b0;
    logic [P-1:0] dOut;
    logic         dValid;
    logic         frameErr;
    logic         overrun;
    logic         busy;
    logic         sampleStrobe;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .packetSize(P),
        .cycleDiv  (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .dReady      (dReady),
        .clrErr      (clrErr),
        .dOut        (dOut),
        .dValid      (dValid),
        .frameErr    (frameErr),
        .overrun     (overrun),
        .busy        (busy),
        .sampleStrobe(sampleStrobe)
    );

    int errors = 0;
    int checks = 0;
    bit en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: line state as seen after two cycles of delay, and the frame
    // position as a plain cycle count since the start bit was seen.
    bit           m_s1 = 1'b1, m_rxs = 1'b1;
    bit           m_active = 1'b0, m_brk = 1'b0;
    int           m_t = 0;
    logic [P-1:0] m_word = '0, m_dout = '0;
    bit           m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    bit           m_load, m_ferr_n;
    int           m_bit;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_s1 = 1'b1; m_rxs = 1'b1; m_active = 1'b0; m_brk = 1'b0; m_t = 0;
            m_word = '0; m_dout = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            m_load = 1'b0;
            m_ferr_n = 1'b0;
            if (m_active) begin
                m_bit = m_t / D;
                if (m_t % D == D / 2) begin
                    if (m_bit == 0) begin
                        if (m_rxs) m_active = 1'b0;
                    end else if (m_bit <= P) begin
                        m_word[m_bit-1] = m_rxs;
                    end else begin
                        m_active = 1'b0;
                        if (m_rxs) m_load = 1'b1;
                        else begin m_ferr_n = 1'b1; m_brk = 1'b1; end
                    end
                end
                m_t++;
            end else if (m_brk) begin
                if (m_rxs) m_brk = 1'b0;
            end else if (!m_rxs) begin
                m_active = 1'b1;
                m_t = 0;
            end
            if (m_load && m_valid && !dReady) m_ovr = 1'b1;
            else if (clrErr) m_ovr = 1'b0;
            if (m_load) begin
                m_dout = m_word;
                m_valid = 1'b1;
            end else if (m_valid && dReady) begin
                m_valid = 1'b0;
            end
            m_ferr = m_ferr_n;
            m_rxs = m_s1;
            m_s1 = rx;
        end
    end

    int n_strobe = 0, n_ferr = 0, n_valid = 0;

    initial forever begin
        @(negedge clk);
        if (en) begin
            check("dValid", 32'(dValid), 32'(m_valid));
            check("dOut", 32'(dOut), 32'(m_dout));
            check("frameErr", 32'(frameErr), 32'(m_ferr));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("busy", 32'(busy), 32'(m_active || m_brk));
            check("sampleStrobe", 32'(sampleStrobe), 32'(m_active && (m_t % D == D / 2)));
            if (sampleStrobe) n_strobe++;
            if (frameErr) n_ferr++;
            if (dValid) n_valid++;
        end
    end

    // dReady/clrErr driver. mode 0: low, 1: high, 2: random, 3: high only on the stop-bit sample.
    int mode = 1;
    bit clr_req = 1'b0, clr_rand = 1'b0;
    int sc = 0;

    initial forever begin
        @(negedge clk);
        #1;
        if (busy !== 1'b1) sc = 0;
        else if (sampleStrobe) sc++;
        case (mode)
            0:       dReady = 1'b0;
            1:       dReady = 1'b1;
            2:       dReady = 1'($urandom_range(0, 1));
            default: dReady = sampleStrobe && (sc == P + 2);
        endcase
        clrErr = clr_req || (clr_rand && $urandom_range(0, 15) == 0);
        clr_req = 1'b0;
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (D - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [P-1:0] data, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < P; i++) drive_bit(data[i]);
        drive_bit(stop);
    endtask

    task automatic hold(input logic level, input int n);
        repeat (n) begin
            @(negedge clk);
            rx = level;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    int s_str, s_fe, s_val;

    task automatic snap();
        settle();
        s_str = n_strobe; s_fe = n_ferr; s_val = n_valid;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b1;
        reset = 1'b0;
        settle();
        check("reset_dValid", 32'(dValid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Good frame, always ready.
        mode = 1;
        snap();
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 2 * D);
        settle();
        check("a5_strobes", 32'(n_strobe - s_str), 32'd10);
        check("a5_valid_cycles", 32'(n_valid - s_val), 32'd1);
        check("a5_ferr", 32'(n_ferr - s_fe), 32'd0);
        check("a5_dOut", 32'(dOut), 32'h0A5);

        // False start: line low only 5 cycles.
        snap();
        hold(1'b0, 5);
        hold(1'b1, 3 * D);
        settle();
        check("fs_strobes", 32'(n_strobe - s_str), 32'd1);
        check("fs_valid_cycles", 32'(n_valid - s_val), 32'd0);
        check("fs_busy", 32'(busy), 32'd0);

        // Bad stop bit, line held low, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, D);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 2 * D);
        settle();
        check("fe_pulses", 32'(n_ferr - s_fe), 32'd1);
        check("fe_valid_cycles", 32'(n_valid - s_val), 32'd1);
        check("fe_dOut", 32'(dOut), 32'h081);

        // Two words with nobody ready: overrun, then cleared.
        mode = 0;
        send_frame(8'h3C, 1'b1);
        hold(1'b1, D);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 2 * D);
        settle();
        check("ovr_dOut", 32'(dOut), 32'h0C3);
        check("ovr_dValid", 32'(dValid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        @(negedge clk);
        clr_req = 1'b1;
        hold(1'b1, 4);
        settle();
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_dOut", 32'(dOut), 32'h0C3);

        // Back-to-back frames, consumption coinciding with the second load.
        mode = 1;
        hold(1'b1, 3);
        mode = 3;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        hold(1'b1, 2 * D);
        settle();
        check("b2b_dOut", 32'(dOut), 32'h034);
        check("b2b_dValid", 32'(dValid), 32'd1);
        check("b2b_overrun", 32'(overrun), 32'd0);

        // Reset during data bit 3.
        mode = 1;
        snap();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (4 * D + D / 2 + 3) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #2;
                check("rst_dValid", 32'(dValid), 32'd0);
                check("rst_dOut", 32'(dOut), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_overrun", 32'(overrun), 32'd0);
                check("rst_strobe", 32'(sampleStrobe), 32'd0);
            end
        join
        hold(1'b1, D);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 2 * D);
        settle();
        check("post_rst_dOut", 32'(dOut), 32'h05A);
        check("post_rst_ferr", 32'(n_ferr - s_fe), 32'd0);

        // Random traffic.
        mode = 2;
        clr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hold(1'b0, $urandom_range(1, 6));
            end else begin
                send_frame(P'($urandom), r != 1);
                if (r == 1) hold(1'b0, $urandom_range(0, 30));
            end
            hold(1'b1, $urandom_range(0, 12));
        end
        hold(1'b1, 3 * D);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
